// File: rtl/led_seq_pkg.sv
// Shared types and helpers for the LED scan sequencer.
//   mode_e    : pattern modes as seen on the cfg_mode port
//   dir_e     : bounce direction
//   calc_div  : clock cycles per pattern step, 0 when the inputs are unusable
package led_seq_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        WALK   = 2'd1,
        BOUNCE = 2'd2,
        BLINK  = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // A zero result means the division is meaningless; the top rejects any
    // result below 2 at elaboration.
    function automatic int calc_div(input int clk_hz, input int st_hz);
        if (st_hz <= 0 || clk_hz <= 0) begin
            return 0;
        end
        return clk_hz / st_hz;
    endfunction

endpackage

// File: rtl/led_seq_prescaler.sv
// Free-running step prescaler.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   clr  : restart the count from 0 on the next edge
//   tick : high during the last cycle of each div-cycle period
module led_seq_prescaler #(
    parameter int div = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (div > 2) ? $clog2(div) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == CNT_W'(div - 1));

    always_comb begin
        if (clr || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_scan_sequencer.sv
// LED pattern scheduler: a prescaler produces a step tick and a mode FSM
// advances one of four patterns (OFF, WALK, BOUNCE, BLINK) on each tick.
// Ports:
//   clk, rst   : system clock, synchronous active-high reset
//   cfg_valid  : config request
//   cfg_ready  : config slot free (pending buffer empty)
//   cfg_mode   : requested mode
//   step       : one-cycle pulse when q shows a new pattern step
//   q          : registered LED drive
module led_scan_sequencer
    import led_seq_pkg::*;
#(
    parameter int clk_freq_hz = 50_000,
    parameter int step_hz     = 8,
    parameter int num_leds    = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [1:0]          cfg_mode,
    output logic                step,
    output logic [num_leds-1:0] q
);

    localparam int DIV   = calc_div(clk_freq_hz, step_hz);
    localparam int POS_W = (num_leds > 2) ? $clog2(num_leds) : 1;

    if (DIV < 2 || num_leds < 2) begin : g_bad_params
        $error("led_scan_sequencer: need clk_freq_hz/step_hz >= 2 and num_leds >= 2");
    end

    localparam logic [POS_W-1:0] POS_LAST = POS_W'(num_leds - 1);

    mode_e                state_q, state_d;
    logic [POS_W-1:0]     pos_q, pos_d;
    dir_e                 dir_q, dir_d;
    logic                 pend_valid_q, pend_valid_d;
    mode_e                pend_mode_q, pend_mode_d;
    logic [num_leds-1:0]  q_q, q_d;
    logic                 step_q, step_d;

    logic tick;
    logic clr;
    logic accept;

    function automatic logic [num_leds-1:0] one_hot(input logic [POS_W-1:0] p);
        return {{(num_leds-1){1'b0}}, 1'b1} << p;
    endfunction

    function automatic logic [num_leds-1:0] entry_pattern(input mode_e m);
        case (m)
            WALK, BOUNCE: return one_hot('0);
            BLINK:        return '1;
            default:      return '0;
        endcase
    endfunction

    led_seq_prescaler #(
        .div (DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

    assign cfg_ready = !pend_valid_q;
    assign accept    = cfg_valid && cfg_ready;
    assign step      = step_q;
    assign q         = q_q;

    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        dir_d        = dir_q;
        pend_valid_d = pend_valid_q;
        pend_mode_d  = pend_mode_q;
        q_d          = q_q;
        step_d       = 1'b0;
        clr          = 1'b0;

        if (state_q == OFF) begin
            // From OFF a new mode takes effect at once and restarts the step period.
            if (accept) begin
                state_d = mode_e'(cfg_mode);
                pos_d   = '0;
                dir_d   = DIR_UP;
                clr     = 1'b1;
                q_d     = entry_pattern(mode_e'(cfg_mode));
            end
        end else begin
            if (tick && pend_valid_q) begin
                // An apply replaces the pattern advance for this tick.
                state_d      = pend_mode_q;
                pos_d        = '0;
                dir_d        = DIR_UP;
                pend_valid_d = 1'b0;
                q_d          = entry_pattern(pend_mode_q);
                step_d       = (pend_mode_q != OFF);
            end else if (tick) begin
                step_d = 1'b1;
                case (state_q)
                    WALK: begin
                        pos_d = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
                        q_d   = one_hot(pos_d);
                    end
                    BOUNCE: begin
                        // Turn around at the ends so neither end LED is shown twice.
                        if (dir_q == DIR_UP) begin
                            if (pos_q == POS_LAST) begin
                                dir_d = DIR_DOWN;
                                pos_d = pos_q - 1'b1;
                            end else begin
                                pos_d = pos_q + 1'b1;
                            end
                        end else begin
                            if (pos_q == '0) begin
                                dir_d = DIR_UP;
                                pos_d = pos_q + 1'b1;
                            end else begin
                                pos_d = pos_q - 1'b1;
                            end
                        end
                        q_d = one_hot(pos_d);
                    end
                    BLINK:   q_d = ~q_q;
                    default: q_d = q_q;
                endcase
            end

            // Accept only happens with the buffer empty, so it never collides with an apply.
            if (accept) begin
                pend_valid_d = 1'b1;
                pend_mode_d  = mode_e'(cfg_mode);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= OFF;
            pos_q        <= '0;
            dir_q        <= DIR_UP;
            pend_valid_q <= 1'b0;
            pend_mode_q  <= OFF;
            q_q          <= '0;
            step_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            dir_q        <= dir_d;
            pend_valid_q <= pend_valid_d;
            pend_mode_q  <= pend_mode_d;
            q_q          <= q_d;
            step_q       <= step_d;
        end
    end

endmodule

// File: tb/tb_led_scan_sequencer.sv
// Bench for led_scan_sequencer with DIV = 10 and four LEDs: directed scenarios
// followed by random configuration traffic against a cycle-level reference model.
module tb_led_scan_sequencer;

    localparam int DIV = 10;
    localparam int N   = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [1:0]   cfg_mode;
    logic         step;
    logic [N-1:0] q;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    int       m_mode;
    int       m_pos;
    bit       m_up;
    int       m_cnt;
    int       pend[$];
    bit [N-1:0] m_q;
    bit       m_step;
    bit       m_last_acc;

    led_scan_sequencer #(
        .clk_freq_hz (80),
        .step_hz     (8),
        .num_leds    (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_mode  (cfg_mode),
        .step      (step),
        .q         (q)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit [N-1:0] entry_of(input int mode);
        case (mode)
            1, 2:    return 4'b0001;
            3:       return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic model_edge(input bit v, input int mode, input bit r);
        bit tick;
        bit acc;
        if (r) begin
            m_mode = 0; m_pos = 0; m_up = 1; m_cnt = 0;
            pend.delete();
            m_q = '0; m_step = 0; m_last_acc = 0;
            return;
        end
        tick   = (m_cnt == DIV - 1);
        acc    = v && (pend.size() == 0);
        m_cnt  = tick ? 0 : m_cnt + 1;
        m_step = 0;
        m_last_acc = acc;
        if (m_mode == 0) begin
            if (acc) begin
                m_mode = mode; m_pos = 0; m_up = 1; m_cnt = 0;
                m_q = entry_of(mode);
            end
        end else begin
            if (tick && pend.size() > 0) begin
                m_mode = pend.pop_front();
                m_pos = 0; m_up = 1;
                m_q = entry_of(m_mode);
                m_step = (m_mode != 0);
            end else if (tick) begin
                m_step = 1;
                if (m_mode == 1) begin
                    m_pos = (m_pos + 1) % N;
                    m_q = 4'b0001 << m_pos;
                end else if (m_mode == 2) begin
                    if (m_up && m_pos == N - 1) begin m_up = 0; m_pos = N - 2; end
                    else if (!m_up && m_pos == 0) begin m_up = 1; m_pos = 1; end
                    else m_pos = m_up ? m_pos + 1 : m_pos - 1;
                    m_q = 4'b0001 << m_pos;
                end else begin
                    m_q = ~m_q;
                end
            end
            if (acc) pend.push_back(mode);
        end
    endtask

    // One clock: drive inputs, advance DUT and model, compare just after the edge.
    task automatic cyc(input bit v, input logic [1:0] mode, input bit r);
        cfg_valid = v;
        cfg_mode  = mode;
        rst       = r;
        @(posedge clk);
        model_edge(v, int'(mode), r);
        #1;
        chk("model_q", q, m_q);
        chk("model_step", step, m_step);
        chk("model_ready", cfg_ready, pend.size() == 0);
    endtask

    task automatic run_until_step();
        bit seen;
        seen = 0;
        for (int i = 0; i < 3 * DIV && !seen; i++) begin
            cyc(0, 2'd0, 0);
            if (step) seen = 1;
        end
        if (!seen) chk("step_timeout", 0, 1);
    endtask

    bit [N-1:0] bseq [8];
    bit [N-1:0] bexp [8];
    int nz;
    int nstep;
    bit seen;
    bit hv;
    logic [1:0] hm;

    initial begin
        cfg_valid = 0; cfg_mode = 0; rst = 1;
        bexp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};

        // Reset and idle
        for (int i = 0; i < 3; i++) cyc(0, 2'd0, 1);
        chk("rst_q", q, 4'b0000);
        chk("rst_ready", cfg_ready, 1);
        nstep = 0;
        for (int i = 0; i < 50; i++) begin
            cyc(0, 2'd0, 0);
            if (step) nstep++;
            if (q != 0) nz++;
        end
        chk("idle_steps", nstep, 0);
        chk("idle_q", q, 4'b0000);

        // WALK from OFF
        cyc(1, 2'd1, 0);
        chk("walk_entry", q, 4'b0001);
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < DIV; i++) cyc(0, 2'd0, 0);
            chk("walk_q", q, (k == 3) ? 4'b0001 : (4'b0010 << k));
            chk("walk_step", step, 1);
        end

        // Pending BLINK accepted 3 cycles after a step
        cyc(0, 2'd0, 0);
        cyc(0, 2'd0, 0);
        cyc(1, 2'd3, 0);
        chk("pend_ready_low", cfg_ready, 0);
        for (int i = 0; i < 6; i++) cyc(0, 2'd0, 0);
        chk("pend_not_yet", q, 4'b0001);
        cyc(0, 2'd0, 0);
        chk("pend_apply_q", q, 4'b1111);
        chk("pend_apply_step", step, 1);
        chk("pend_apply_ready", cfg_ready, 1);
        for (int i = 0; i < DIV; i++) cyc(0, 2'd0, 0);
        chk("blink_toggle", q, 4'b0000);

        // Back-pressure: fill pending with WALK, then hold BOUNCE request
        cyc(1, 2'd1, 0);
        chk("bp_full", cfg_ready, 0);
        seen = 0;
        for (int i = 0; i < 3 * DIV && !seen; i++) begin
            cyc(1, 2'd2, 0);
            if (cfg_ready) seen = 1;
        end
        chk("bp_ready_rise", seen, 1);
        chk("bp_walk_applied", q, 4'b0001);
        cyc(1, 2'd2, 0);
        chk("bp_accepted", cfg_ready, 0);
        run_until_step();
        chk("bp_bounce_entry", q, 4'b0001);
        chk("bp_ready_back", cfg_ready, 1);
        for (int i = 0; i < 4; i++) run_until_step();
        chk("bp_bounce_turn", q, 4'b0100);

        // BOUNCE sequence from OFF
        cyc(0, 2'd0, 1);
        cyc(1, 2'd2, 0);
        bseq[0] = q;
        for (int i = 1; i < 8; i++) begin
            run_until_step();
            bseq[i] = q;
        end
        for (int i = 0; i < 8; i++) chk("bounce_seq", bseq[i], bexp[i]);
        for (int i = 1; i < 8; i++)
            chk("bounce_no_repeat_end",
                (bseq[i] == bseq[i-1]) && (bseq[i] == 4'b1000 || bseq[i] == 4'b0001), 0);

        // Mid-run reset with pending config, BOUNCE at pos 2
        cyc(0, 2'd0, 1);
        cyc(1, 2'd2, 0);
        run_until_step();
        run_until_step();
        chk("mid_pos2", q, 4'b0100);
        cyc(1, 2'd1, 0);
        chk("mid_pend_full", cfg_ready, 0);
        cyc(0, 2'd0, 1);
        chk("mid_rst_q", q, 4'b0000);
        chk("mid_rst_ready", cfg_ready, 1);
        nz = 0;
        for (int i = 0; i < 3 * DIV; i++) begin
            cyc(0, 2'd0, 0);
            if (q != 0 || step) nz++;
        end
        chk("mid_pend_dropped", nz, 0);

        // Random traffic; a request waiting for ready keeps its mode stable
        hv = 0; hm = 0;
        for (int i = 0; i < 3000; i++) begin
            bit r;
            r = ($urandom_range(0, 299) == 0);
            if (!(hv && !m_last_acc)) begin
                hv = ($urandom_range(0, 5) == 0);
                hm = 2'($urandom_range(0, 3));
            end
            cyc(hv, hm, r);
            if (r) hv = 0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
